// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle between the mips core, the arbiter and the unified SRAM.
// slave = arbiter view; master = core + memory view.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_gnt;
  logic              inst_rvalid;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic [3:0]        data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_gnt;
  logic              data_rvalid;
  logic [DATA_W-1:0] data_rdata;

  logic              sram_en;
  logic [3:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_gnt, inst_rvalid, inst_rdata,
    input  data_req, data_wen, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_gnt, inst_rvalid, inst_rdata,
    output data_req, data_wen, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between mips fetch and data requesters.
// Define ARB_ROUND_ROBIN_EN for alternating grants under contention instead of data priority + starvation cap.
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_port_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_e;
  typedef enum logic       {SIDE_INST, SIDE_DATA}         side_e;

  typedef struct packed {
    logic              en;
    logic [3:0]        wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

  owner_e           rd_owner_q, rd_owner_d;
  side_e            last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] starve_q,   starve_d;
  logic             inst_gnt,   data_gnt;
  logic             both_req;
  sram_req_t        sram_req;

  assign both_req = bus.inst_req && bus.data_req;

  // Grant selection; grants are held low during reset regardless of requests.
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (!rst) begin
      if (both_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (last_gnt_q == SIDE_DATA) inst_gnt = 1'b1;
        else                         data_gnt = 1'b1;
`else
        if (starve_q == CNT_MAX) inst_gnt = 1'b1;
        else                     data_gnt = 1'b1;
`endif
      end else begin
        inst_gnt = bus.inst_req;
        data_gnt = bus.data_req;
      end
    end
  end

  always_comb begin
    sram_req = '0;
    if (inst_gnt) begin
      sram_req.en   = 1'b1;
      sram_req.addr = bus.inst_addr;
    end else if (data_gnt) begin
      sram_req.en    = 1'b1;
      sram_req.wen   = bus.data_wen;
      sram_req.addr  = bus.data_addr;
      sram_req.wdata = bus.data_wdata;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    last_gnt_d = last_gnt_q;
    if (inst_gnt) begin
      rd_owner_d = OWN_INST;
      last_gnt_d = SIDE_INST;
    end else if (data_gnt) begin
      last_gnt_d = SIDE_DATA;
      if (bus.data_wen == 4'h0) rd_owner_d = OWN_DATA;
    end
  end

  // Counts consecutive cycles fetch loses contention; saturates at the cap.
  always_comb begin
    starve_d = starve_q;
`ifdef ARB_ROUND_ROBIN_EN
    starve_d = '0;
`else
    if (!bus.inst_req || inst_gnt)             starve_d = '0;
    else if (data_gnt && starve_q != CNT_MAX)  starve_d = starve_q + 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner_q <= OWN_NONE;
      last_gnt_q <= SIDE_INST;
      starve_q   <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      last_gnt_q <= last_gnt_d;
      starve_q   <= starve_d;
    end
  end

  assign bus.inst_gnt    = inst_gnt;
  assign bus.data_gnt    = data_gnt;
  assign bus.sram_en     = sram_req.en;
  assign bus.sram_wen    = sram_req.wen;
  assign bus.sram_addr   = sram_req.addr;
  assign bus.sram_wdata  = sram_req.wdata;

  assign bus.inst_rvalid = (rd_owner_q == OWN_INST);
  assign bus.data_rvalid = (rd_owner_q == OWN_DATA);
  assign bus.inst_rdata  = bus.inst_rvalid ? bus.sram_rdata : '0;
  assign bus.data_rdata  = bus.data_rvalid ? bus.sram_rdata : '0;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) !(inst_gnt && data_gnt));
  a_rd_exclusive: assert property (@(posedge clk) disable iff (rst)
                                   !(bus.inst_rvalid && bus.data_rvalid));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed-vector bench for sram_port_arbiter: reset, single reads, stores,
// interleaved routing, contention pattern and mid-operation reset.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.inst_req   = 1'b0;
    bus.inst_addr  = '0;
    bus.data_req   = 1'b0;
    bus.data_wen   = 4'h0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    bus.sram_rdata = '0;
  endtask

  // Advance one cycle; inputs are driven 1ns after the edge, outputs checked 1ns later.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] exp_inst;

  initial begin
    rst = 1'b1;
    idle_in();
    bus.inst_req   = 1'b1;
    bus.data_req   = 1'b1;
    bus.sram_rdata = 32'h1234_5678;
    #2;
    chk("rst_inst_gnt", bus.inst_gnt, 0);
    chk("rst_data_gnt", bus.data_gnt, 0);
    chk("rst_sram_en", bus.sram_en, 0);
    chk("rst_sram_addr", bus.sram_addr, 0);
    chk("rst_inst_rvalid", bus.inst_rvalid, 0);
    chk("rst_data_rdata", bus.data_rdata, 0);

    // Single fetch from the boot vector
    nxt();
    rst = 1'b0;
    idle_in();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'hBFC0_0000;
    #1;
    chk("fetch_gnt", bus.inst_gnt, 1);
    chk("fetch_en", bus.sram_en, 1);
    chk("fetch_addr", bus.sram_addr, 32'hBFC0_0000);
    chk("fetch_wen", bus.sram_wen, 0);
    nxt();
    idle_in();
    bus.sram_rdata = 32'h3C08_0001;
    #1;
    chk("fetch_rvalid", bus.inst_rvalid, 1);
    chk("fetch_rdata", bus.inst_rdata, 32'h3C08_0001);
    chk("fetch_no_drv", bus.data_rvalid, 0);
    chk("idle_en", bus.sram_en, 0);

    // Data store: no read response follows
    nxt();
    idle_in();
    bus.data_req   = 1'b1;
    bus.data_wen   = 4'hF;
    bus.data_addr  = 32'h10;
    bus.data_wdata = 32'hDEAD_BEEF;
    #1;
    chk("st_gnt", bus.data_gnt, 1);
    chk("st_wen", bus.sram_wen, 4'hF);
    chk("st_addr", bus.sram_addr, 32'h10);
    chk("st_wdata", bus.sram_wdata, 32'hDEAD_BEEF);

    // Interleaved inst/data reads
    nxt();
    idle_in();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h100;
    bus.sram_rdata = 32'h5555_AAAA;
    #1;
    chk("st_no_drv", bus.data_rvalid, 0);
    chk("st_no_irv", bus.inst_rvalid, 0);
    chk("alt_a_gnt", bus.inst_gnt, 1);
    nxt();
    idle_in();
    bus.data_req   = 1'b1;
    bus.data_addr  = 32'h200;
    bus.sram_rdata = 32'h1111_1111;
    #1;
    chk("alt_b_gnt", bus.data_gnt, 1);
    chk("alt_b_addr", bus.sram_addr, 32'h200);
    chk("alt_b_irv", bus.inst_rvalid, 1);
    chk("alt_b_irdata", bus.inst_rdata, 32'h1111_1111);
    chk("alt_b_drv", bus.data_rvalid, 0);
    nxt();
    idle_in();
    bus.inst_req   = 1'b1;
    bus.inst_addr  = 32'h104;
    bus.sram_rdata = 32'h2222_2222;
    #1;
    chk("alt_c_gnt", bus.inst_gnt, 1);
    chk("alt_c_drv", bus.data_rvalid, 1);
    chk("alt_c_drdata", bus.data_rdata, 32'h2222_2222);
    chk("alt_c_irv", bus.inst_rvalid, 0);
    chk("alt_c_irdata", bus.inst_rdata, 0);
    nxt();
    idle_in();
    bus.sram_rdata = 32'h3333_3333;
    #1;
    chk("alt_d_irdata", bus.inst_rdata, 32'h3333_3333);
    chk("alt_d_drdata", bus.data_rdata, 0);

    // Continuous contention starting from reset
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    idle_in();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h80;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h40;
`ifdef ARB_ROUND_ROBIN_EN
    exp_inst = 10'b10_1010_1010;
`else
    exp_inst = 10'b10_0001_0000;
`endif
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("cont_ignt_%0d", i), bus.inst_gnt, exp_inst[i]);
      chk($sformatf("cont_dgnt_%0d", i), bus.data_gnt, !exp_inst[i]);
      if (i > 0) chk($sformatf("cont_irv_%0d", i), bus.inst_rvalid, exp_inst[i-1]);
      nxt();
    end

    // Reset asserted the cycle after a fetch grant drops the pending response
    bus.data_req = 1'b0;
    #1;
    chk("mid_gnt", bus.inst_gnt, 1);
    nxt();
    bus.data_req   = 1'b1;
    bus.sram_rdata = 32'hAAAA_5555;
    rst = 1'b1;
    #1;
    chk("mid_irv", bus.inst_rvalid, 0);
    chk("mid_irdata", bus.inst_rdata, 0);
    chk("mid_igrant", bus.inst_gnt, 0);
    chk("mid_dgrant", bus.data_gnt, 0);
    chk("mid_en", bus.sram_en, 0);
    chk("mid_addr", bus.sram_addr, 0);
    nxt();
    idle_in();
    rst = 1'b0;
    nxt();
    chk("post_irv", bus.inst_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
